// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit serializer for the Kabeta UART peripheral. A one-deep holding
// buffer accepts a byte per TxWrEn strobe and hands it to a shift register,
// which emits a start bit, 7 or 8 data bits LSB-first, an optional parity
// bit and 1 or 2 stop bits on Txd. The frame format and bit period are
// latched when the byte moves into the shifter, so register writes made
// during a frame only take effect on the next one.
//
// Build option: define UART_TX_BREAK_EN to honour TxBreak (line held low
// while idle, transfers held off). Without it TxBreak is ignored.
//
// Ports:
//   Clock           rising-edge clock for all state
//   Reset           asynchronous, active-low reset
//   TxData[7:0]     byte to send, sampled when TxWrEn=1
//   TxWrEn          single-cycle write strobe
//   DataLenLimit    data bits minus one (7 -> 8 bits, anything else -> 7)
//   StopLenLimit    0 -> 1 stop bit, 1 -> 2 stop bits
//   ParityEn        insert a parity bit after the data bits
//   ParityPolarity  0 -> even, 1 -> odd
//   BaudLimit       bit period is BaudLimit+1 clocks
//   TxBreak         break request (UART_TX_BREAK_EN builds only)
//   TxBusy          byte buffered or frame in progress (registered)
//   TxReady         one-cycle pulse when the buffer hands a byte to the shifter
//   Txd             registered serial output, idles high
module uart_tx_serializer #(
  parameter int BAUD_W = 14
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        TxData,
  input  logic              TxWrEn,
  input  logic [2:0]        DataLenLimit,
  input  logic              StopLenLimit,
  input  logic              ParityEn,
  input  logic              ParityPolarity,
  input  logic [BAUD_W-1:0] BaudLimit,
  input  logic              TxBreak,
  output logic              TxBusy,
  output logic              TxReady,
  output logic              Txd
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

  txState_t          state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext, baudLim;
  logic [2:0]        bitCnt, bitCntNext, dataLim;
  logic              stopCnt, stopCntNext, stopLim;
  logic              parEn, parPol;
  logic              holdValid, holdValidNext, holdLoad;
  logic [7:0]        holdData, shifter, shiftNext;
  logic              parityAcc, parityNext;
  logic              bitEnd, lastStop, transfer, breakActive;
  logic              txdNext, busyNext;

`ifdef UART_TX_BREAK_EN
  assign breakActive = TxBreak;
`else
  logic unusedBreak;
  assign unusedBreak = TxBreak;
  assign breakActive = 1'b0;
`endif

  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    stopCntNext   = stopCnt;
    shiftNext     = shifter;
    parityNext    = parityAcc;
    holdValidNext = holdValid;
    holdLoad      = 1'b0;
    txdNext       = 1'b1;

    bitEnd   = (baudCnt == baudLim);
    lastStop = (state == STOP) && bitEnd && (stopCnt == stopLim);
    // A buffered byte moves to the shifter either from idle or on the very
    // last clock of the final stop bit, which gives gap-free back-to-back frames.
    transfer = holdValid && !breakActive && ((state == IDLE) || lastStop);

    case (state)
      IDLE: ;
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          bitCntNext = 3'd0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          // Parity accumulates only the bits actually shifted out.
          parityNext = parityAcc ^ shifter[0];
          shiftNext  = {1'b0, shifter[7:1]};
          if (bitCnt == dataLim) begin
            stateNext   = parEn ? PARITY : STOP;
            stopCntNext = 1'b0;
          end else begin
            bitCntNext = bitCnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNext   = STOP;
          stopCntNext = 1'b0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (stopCnt == stopLim) stateNext = IDLE;
          else stopCntNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    baudNext = ((state == IDLE) || bitEnd) ? '0 : baudCnt + BAUD_W'(1);

    if (transfer) begin
      stateNext  = START;
      shiftNext  = holdData;
      parityNext = 1'b0;
      baudNext   = '0;
    end

    // The buffer refills in the same cycle it empties into the shifter.
    if (transfer) begin
      holdValidNext = TxWrEn;
      holdLoad      = TxWrEn;
    end else if (TxWrEn && !holdValid) begin
      holdValidNext = 1'b1;
      holdLoad      = 1'b1;
    end

    // Txd is computed from next-cycle state so the pin is driven by a flop.
    case (stateNext)
      IDLE:    txdNext = !breakActive;
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftNext[0];
      PARITY:  txdNext = parityNext ^ parPol;
      STOP:    txdNext = 1'b1;
      default: txdNext = 1'b1;
    endcase

    busyNext = holdValidNext || (stateNext != IDLE) || breakActive;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitCnt    <= 3'd0;
      stopCnt   <= 1'b0;
      holdValid <= 1'b0;
      Txd       <= 1'b1;
      TxBusy    <= 1'b0;
      TxReady   <= 1'b0;
      dataLim   <= 3'd7;
      stopLim   <= 1'b0;
      parEn     <= 1'b0;
      parPol    <= 1'b0;
      baudLim   <= '0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudNext;
      bitCnt    <= bitCntNext;
      stopCnt   <= stopCntNext;
      holdValid <= holdValidNext;
      Txd       <= txdNext;
      TxBusy    <= busyNext;
      TxReady   <= transfer;
      if (transfer) begin
        dataLim <= (DataLenLimit == 3'd7) ? 3'd7 : 3'd6;
        stopLim <= StopLenLimit;
        parEn   <= ParityEn;
        parPol  <= ParityPolarity;
        baudLim <= BaudLimit;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (holdLoad) holdData <= TxData;
    shifter   <= shiftNext;
    parityAcc <= parityNext;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Expected frames are built from
// the byte and format at write time, queued, and compared clock by clock
// against Txd once the DUT announces the transfer with TxReady.
module tb_uart_tx_serializer;
  localparam int BAUD_W = 14;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [7:0]        TxData = '0;
  logic              TxWrEn = 1'b0;
  logic [2:0]        DataLenLimit = 3'd7;
  logic              StopLenLimit = 1'b0;
  logic              ParityEn = 1'b0;
  logic              ParityPolarity = 1'b0;
  logic [BAUD_W-1:0] BaudLimit = '0;
  logic              TxBreak = 1'b0;
  logic              TxBusy, TxReady, Txd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bits;
    int          n;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] dl;
    logic       sl;
    logic       pe;
    logic       pp;
    int         b;
  } fmt_t;

  frame_t expQ[$];

  uart_tx_serializer #(.BAUD_W(BAUD_W)) dut (
    .Clock(Clock), .Reset(Reset), .TxData(TxData), .TxWrEn(TxWrEn),
    .DataLenLimit(DataLenLimit), .StopLenLimit(StopLenLimit),
    .ParityEn(ParityEn), .ParityPolarity(ParityPolarity),
    .BaudLimit(BaudLimit), .TxBreak(TxBreak),
    .TxBusy(TxBusy), .TxReady(TxReady), .Txd(Txd)
  );

  always #5 Clock = ~Clock;

  // Reference frame: start, data LSB-first, optional parity, stop bits.
  function automatic frame_t buildFrame(input logic [7:0] d, input logic [2:0] dl,
                                        input logic sl, input logic pe, input logic pp);
    frame_t f;
    int     nb;
    logic   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    f.n       = 1;
    p         = pp;
    nb        = (dl == 3'd7) ? 8 : 7;
    for (int i = 0; i < nb; i++) begin
      f.bits[f.n] = d[i];
      p = p ^ d[i];
      f.n++;
    end
    if (pe) begin
      f.bits[f.n] = p;
      f.n++;
    end
    f.n += sl ? 2 : 1;
    return f;
  endfunction

  task automatic setCfg(input logic [2:0] dl, input logic sl, input logic pe,
                        input logic pp, input logic [BAUD_W-1:0] bl);
    DataLenLimit   = dl;
    StopLenLimit   = sl;
    ParityEn       = pe;
    ParityPolarity = pp;
    BaudLimit      = bl;
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic writeByte(input logic [7:0] d, input bit expectFrame);
    TxData = d;
    TxWrEn = 1'b1;
    if (expectFrame)
      expQ.push_back(buildFrame(d, DataLenLimit, StopLenLimit, ParityEn, ParityPolarity));
    @(negedge Clock);
    TxWrEn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    checks++;
    if (Txd !== 1'b1 || TxBusy !== 1'b0 || TxReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: Txd=%b TxBusy=%b TxReady=%b, want 1 0 0", Txd, TxBusy, TxReady);
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (Txd !== 1'b1 || TxBusy !== 1'b0 || TxReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: Txd=%b TxBusy=%b TxReady=%b, want 1 0 0", Txd, TxBusy, TxReady);
    end
  endtask

  task automatic test_basic();
    frame_t f;
    setCfg(3'd7, 1'b0, 1'b0, 1'b0, 14'd3);
    repeat (3) @(negedge Clock);
    writeByte(8'hA5, 1'b1);
    checks++;
    if (TxReady !== 1'b0 || TxBusy !== 1'b1) begin
      errors++;
      $display("FAIL basic_buffered: TxReady=%b TxBusy=%b, want 0 1", TxReady, TxBusy);
    end
    @(negedge Clock);
    checks++;
    if (TxReady !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_latency: TxReady=%b, want 1", TxReady);
    end
    f = expQ.pop_front();
    for (int j = 0; j < f.n * 4; j++) begin
      checks++;
      if (Txd !== f.bits[j/4] || TxBusy !== 1'b1 || TxReady !== (j == 0)) begin
        errors++;
        $display("FAIL basic_frame clk %0d: Txd=%b TxBusy=%b TxReady=%b, want %b 1 %b",
                 j, Txd, TxBusy, TxReady, f.bits[j/4], (j == 0));
      end
      @(negedge Clock);
    end
    checks++;
    if (TxBusy !== 1'b0 || Txd !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_fall: TxBusy=%b Txd=%b, want 0 1", TxBusy, Txd);
    end
  endtask

  // Format table; format inputs are scrambled mid-frame to show they are latched.
  task automatic test_formats();
    fmt_t tbl[5];
    tbl[0] = '{8'h03, 3'd6, 1'b1, 1'b1, 1'b0, 1};
    tbl[1] = '{8'h03, 3'd6, 1'b1, 1'b1, 1'b1, 1};
    tbl[2] = '{8'hFF, 3'd2, 1'b0, 1'b1, 1'b1, 0};
    tbl[3] = '{8'h80, 3'd7, 1'b0, 1'b1, 1'b0, 0};
    tbl[4] = '{8'hC3, 3'd7, 1'b1, 1'b0, 1'b0, 5};
    for (int k = 0; k < 5; k++) begin
      frame_t f;
      int     per;
      per = tbl[k].b + 1;
      setCfg(tbl[k].dl, tbl[k].sl, tbl[k].pe, tbl[k].pp, BAUD_W'(tbl[k].b));
      writeByte(tbl[k].d, 1'b1);
      @(negedge Clock);
      checks++;
      if (TxReady !== 1'b1) begin
        errors++;
        $display("FAIL fmt%0d_ready: TxReady=%b, want 1", k, TxReady);
      end
      f = expQ.pop_front();
      setCfg(~tbl[k].dl, ~tbl[k].sl, ~tbl[k].pe, ~tbl[k].pp, BAUD_W'(tbl[k].b + 2));
      for (int j = 0; j < f.n * per; j++) begin
        checks++;
        if (Txd !== f.bits[j/per] || TxBusy !== 1'b1) begin
          errors++;
          $display("FAIL fmt%0d_frame clk %0d: Txd=%b TxBusy=%b, want %b 1",
                   k, j, Txd, TxBusy, f.bits[j/per]);
        end
        @(negedge Clock);
      end
      checks++;
      if (TxBusy !== 1'b0 || Txd !== 1'b1) begin
        errors++;
        $display("FAIL fmt%0d_end: TxBusy=%b Txd=%b, want 0 1", k, TxBusy, Txd);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    setCfg(3'd7, 1'b0, 1'b0, 1'b0, 14'd2);
    writeByte(8'h11, 1'b1);
    @(negedge Clock);
    for (int fi = 0; fi < 2; fi++) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL b2b_queue frame %0d: queued=0, want 1", fi);
      end else begin
        f = expQ.pop_front();
        for (int j = 0; j < f.n * 3; j++) begin
          checks++;
          if (Txd !== f.bits[j/3] || TxBusy !== 1'b1 || TxReady !== (j == 0)) begin
            errors++;
            $display("FAIL b2b_frame%0d clk %0d: Txd=%b TxBusy=%b TxReady=%b, want %b 1 %b",
                     fi, j, Txd, TxBusy, TxReady, f.bits[j/3], (j == 0));
          end
          TxWrEn = (fi == 0) && (j == 3 || j == 8);
          TxData = (j == 3) ? 8'h22 : 8'h33;
          if (fi == 0 && j == 3)
            expQ.push_back(buildFrame(8'h22, DataLenLimit, StopLenLimit, ParityEn, ParityPolarity));
          @(negedge Clock);
        end
      end
    end
    TxWrEn = 1'b0;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (TxBusy !== 1'b0 || TxReady !== 1'b0 || Txd !== 1'b1) begin
        errors++;
        $display("FAIL b2b_dropped clk %0d: TxBusy=%b TxReady=%b Txd=%b, want 0 0 1",
                 j, TxBusy, TxReady, Txd);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    setCfg(3'd7, 1'b0, 1'b0, 1'b0, 14'd3);
    writeByte(8'hF0, 1'b1);
    @(negedge Clock);
    f = expQ.pop_front();
    repeat (6) @(negedge Clock);
    checks++;
    if (Txd !== f.bits[1] || TxBusy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: Txd=%b TxBusy=%b, want %b 1", Txd, TxBusy, f.bits[1]);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (Txd !== 1'b1 || TxBusy !== 1'b0 || TxReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: Txd=%b TxBusy=%b TxReady=%b, want 1 0 0", Txd, TxBusy, TxReady);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (Txd !== 1'b1 || TxBusy !== 1'b0 || TxReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: Txd=%b TxBusy=%b TxReady=%b, want 1 0 0", Txd, TxBusy, TxReady);
    end
    setCfg(3'd7, 1'b0, 1'b0, 1'b0, 14'd1);
    writeByte(8'h3C, 1'b1);
    @(negedge Clock);
    f = expQ.pop_front();
    for (int j = 0; j < f.n * 2; j++) begin
      checks++;
      if (Txd !== f.bits[j/2] || TxReady !== (j == 0)) begin
        errors++;
        $display("FAIL rst_clean_frame clk %0d: Txd=%b TxReady=%b, want %b %b",
                 j, Txd, TxReady, f.bits[j/2], (j == 0));
      end
      @(negedge Clock);
    end
    checks++;
    if (TxBusy !== 1'b0) begin
      errors++;
      $display("FAIL rst_clean_end: TxBusy=%b, want 0", TxBusy);
    end
  endtask

  task automatic test_break();
    frame_t f;
    setCfg(3'd7, 1'b0, 1'b0, 1'b0, 14'd1);
    TxBreak = 1'b1;
    @(negedge Clock);
    writeByte(8'h55, 1'b1);
`ifdef UART_TX_BREAK_EN
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (Txd !== 1'b0 || TxReady !== 1'b0 || TxBusy !== 1'b1) begin
        errors++;
        $display("FAIL break_hold clk %0d: Txd=%b TxReady=%b TxBusy=%b, want 0 0 1",
                 j, Txd, TxReady, TxBusy);
      end
      @(negedge Clock);
    end
    TxBreak = 1'b0;
`endif
    @(negedge Clock);
    checks++;
    if (TxReady !== 1'b1) begin
      errors++;
      $display("FAIL break_start: TxReady=%b, want 1", TxReady);
    end
    f = expQ.pop_front();
    for (int j = 0; j < f.n * 2; j++) begin
      checks++;
      if (Txd !== f.bits[j/2] || TxBusy !== 1'b1) begin
        errors++;
        $display("FAIL break_frame clk %0d: Txd=%b TxBusy=%b, want %b 1", j, Txd, TxBusy, f.bits[j/2]);
      end
      @(negedge Clock);
    end
    TxBreak = 1'b0;
    @(negedge Clock);
    checks++;
    if (TxBusy !== 1'b0 || Txd !== 1'b1) begin
      errors++;
      $display("FAIL break_end: TxBusy=%b Txd=%b, want 0 1", TxBusy, Txd);
    end
  endtask

  initial begin
    Reset = 1'b1;
    #1 Reset = 1'b0;
    test_reset();
    test_basic();
    test_formats();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d frames left, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
